// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// State encoding, access-legality check and counter sizing used by cpu and arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } arb_state_e;

    // Data access is rejected when misaligned, past the end of RAM, or read+write at once.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input int unsigned nmem
    );
        logic [31:0] widx;
        widx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (widx >= nmem) || (rd && wr);
    endfunction

    function automatic int starve_cw(input int maxv);
        int w;
        w = $clog2(maxv + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants issued while a fetch waits; flags when fetch must win.
// Zero-latency compare, count updates on the grant edge; no backpressure of its own.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CW         = starve_cw(STARVE_MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic data_grant_i,
    input  logic fetch_grant_i,
    output logic fetch_wins_o
);

    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    assign fetch_wins_o = if_req_i && (cnt_q == MAXV);

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_grant_i || (idle_i && !if_req_i)) begin
            cnt_d = '0;
        end else if (data_grant_i && if_req_i && (cnt_q != MAXV)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and data load/store.
// Grant is combinational in IDLE, ready one cycle later; requesters hold until ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NMEM       = 64,
    parameter int STARVE_MAX = 3,
    localparam int AW        = $clog2(NMEM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_instr,
    output logic          if_ready,
    input  logic          mem_memread,
    input  logic          mem_memwrite,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic [31:0]   mem_memdata,
    output logic          mem_ready,
    output logic          mem_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    arb_state_e state_q, state_d;
    logic       err_q, err_d;
    logic       wr_q, wr_d;

    logic mem_req;
    logic data_err;
    logic idle;
    logic fetch_wins;
    logic grant_if;
    logic grant_mem;

    // Fetch addresses wrap inside the RAM, so the high and byte-offset bits are ignored.
    logic unused_if_addr_bits;
    assign unused_if_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0]};

    assign mem_req   = mem_memread | mem_memwrite;
    assign data_err  = addr_err(mem_addr, mem_memread, mem_memwrite, NMEM);
    assign idle      = (state_q == IDLE) && !reset;
    assign grant_if  = idle && if_req && (!mem_req || fetch_wins);
    assign grant_mem = idle && mem_req && !grant_if;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk           (clk),
        .reset         (reset),
        .idle_i        (idle),
        .if_req_i      (if_req),
        .data_grant_i  (grant_mem),
        .fetch_grant_i (grant_if),
        .fetch_wins_o  (fetch_wins)
    );

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        wr_d        = wr_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        if_ready    = 1'b0;
        if_instr    = '0;
        mem_ready   = 1'b0;
        mem_err     = 1'b0;
        mem_memdata = '0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        ram_en   = 1'b1;
                        ram_addr = if_addr[AW+1:2];
                        state_d  = IF_WAIT;
                    end else if (grant_mem) begin
                        // A rejected access still occupies the slot but never touches RAM.
                        err_d   = data_err;
                        wr_d    = mem_memwrite;
                        state_d = MEM_WAIT;
                        if (!data_err) begin
                            ram_en    = 1'b1;
                            ram_we    = mem_memwrite;
                            ram_addr  = mem_addr[AW+1:2];
                            ram_wdata = mem_memwrite ? mem_wdata : 32'h0;
                        end
                    end
                end
                IF_WAIT: begin
                    if_ready = 1'b1;
                    if_instr = ram_rdata;
                    state_d  = IDLE;
                end
                MEM_WAIT: begin
                    mem_ready = 1'b1;
                    mem_err   = err_q;
                    if (!err_q && !wr_q) begin
                        mem_memdata = ram_rdata;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int NMEM       = 64;
    localparam int AW         = $clog2(NMEM);
    localparam int STARVE_MAX = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_instr;
    logic          if_ready;
    logic          mem_memread;
    logic          mem_memwrite;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_memdata;
    logic          mem_ready;
    logic          mem_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = 32'h0;

    logic [31:0] ram    [NMEM];
    logic [31:0] shadow [NMEM];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NMEM(NMEM), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_instr     (if_instr),
        .if_ready     (if_ready),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_memdata  (mem_memdata),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h8C01_0004 : (32'h1000_0000 + 32'(i) * 32'h0101_0101);
    endfunction

    // Synchronous RAM: read data appears the cycle after the strobe.
    initial begin : ram_model
        for (int i = 0; i < NMEM; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_en) begin
                ram_rdata <= ram[ram_addr];
                if (ram_we) ram[ram_addr] = ram_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        mem_memread = 1'b0; mem_memwrite = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [7:0]  order;
    int          ngr, first_rdy;
    logic [31:0] err_addr [3] = '{32'h6, 32'h10, 32'(NMEM * 4)};
    logic        err_wr   [3] = '{1'b0, 1'b1, 1'b0};

    // Reference model state: what is in flight and how many data grants a fetch has watched.
    int          busy, consec, f_wait, m_wait, idx, k;
    logic        f_act, m_act, dropped, take_f, mreq, perr;
    logic [31:0] pend;
    logic        e_en, e_we, e_ifr, e_mr, e_me;
    logic [31:0] e_addr, e_wd, e_ii, e_md;

    initial begin
        for (int i = 0; i < NMEM; i++) shadow[i] = init_word(i);
        idle_inputs();
        reset = 1'b1; if_req = 1'b1; mem_memread = 1'b1;
        smp();
        chk("rst_ram_en",    32'(ram_en),    32'd0);
        chk("rst_if_ready",  32'(if_ready),  32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_err",   32'(mem_err),   32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        nxt();
        reset = 1'b0; idle_inputs();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h8;
        smp();
        chk("fetch_ram_en",   32'(ram_en),   32'd1);
        chk("fetch_ram_addr", 32'(ram_addr), 32'd2);
        chk("fetch_ram_we",   32'(ram_we),   32'd0);
        nxt(); smp();
        chk("fetch_if_ready", 32'(if_ready), 32'd1);
        chk("fetch_if_instr", if_instr,      32'h8C01_0004);
        nxt(); idle_inputs();

        // Store then load
        mem_memwrite = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        smp();
        chk("sw_ram_we",    32'(ram_we),   32'd1);
        chk("sw_ram_addr",  32'(ram_addr), 32'd4);
        chk("sw_ram_wdata", ram_wdata,     32'hDEAD_BEEF);
        nxt(); smp();
        chk("sw_mem_ready", 32'(mem_ready), 32'd1);
        chk("sw_memdata",   mem_memdata,    32'h0);
        nxt(); idle_inputs();
        shadow[4] = 32'hDEAD_BEEF;
        mem_memread = 1'b1; mem_addr = 32'h10;
        smp();
        chk("lw_ram_en", 32'(ram_en), 32'd1);
        nxt(); smp();
        chk("lw_mem_ready", 32'(mem_ready), 32'd1);
        chk("lw_mem_err",   32'(mem_err),   32'd0);
        chk("lw_memdata",   mem_memdata,    32'hDEAD_BEEF);
        nxt(); idle_inputs();

        // Contention: both held continuously
        order = 8'h0; ngr = 0; first_rdy = -1;
        if_req = 1'b1; if_addr = 32'h20; mem_memread = 1'b1; mem_addr = 32'h40;
        for (int c = 0; c < 16; c++) begin
            smp();
            if (ram_en) begin order = {order[6:0], (ram_addr == AW'(8))}; ngr++; end
            if (if_ready && first_rdy < 0) first_rdy = c;
            nxt();
        end
        idle_inputs();
        chk("contention_order",  32'(order),     32'h11);
        chk("contention_grants", 32'(ngr),       32'd8);
        chk("contention_fwait",  32'(first_rdy), 32'd7);

        // Rejected accesses
        for (int e = 0; e < 3; e++) begin
            mem_memread = 1'b1; mem_memwrite = err_wr[e]; mem_addr = err_addr[e];
            mem_wdata = 32'h1234_5678;
            smp();
            chk("err_ram_en", 32'(ram_en), 32'd0);
            nxt(); smp();
            chk("err_mem_ready", 32'(mem_ready), 32'd1);
            chk("err_mem_err",   32'(mem_err),   32'd1);
            chk("err_memdata",   mem_memdata,    32'h0);
            nxt(); idle_inputs();
        end
        mem_memread = 1'b1; mem_addr = 32'h10;
        smp(); nxt(); smp();
        chk("err_no_write", mem_memdata, 32'hDEAD_BEEF);
        nxt(); idle_inputs();

        // Reset the cycle after a fetch grant
        if_req = 1'b1; if_addr = 32'h8;
        smp();
        chk("rstmid_grant", 32'(ram_en), 32'd1);
        nxt(); reset = 1'b1;
        smp();
        chk("rstmid_no_ready", 32'(if_ready), 32'd0);
        nxt(); reset = 1'b0;
        smp();
        chk("rstmid_regrant", 32'(ram_addr), 32'd2);
        nxt(); smp();
        chk("rstmid_ready", 32'(if_ready), 32'd1);
        chk("rstmid_instr", if_instr,      32'h8C01_0004);
        nxt(); idle_inputs();

        // Reset clears the starvation count built up by three data grants
        if_req = 1'b1; if_addr = 32'h20; mem_memread = 1'b1; mem_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin smp(); nxt(); end
        reset = 1'b1;
        smp();
        chk("rstcnt_abort_ready", 32'(mem_ready), 32'd0);
        nxt(); reset = 1'b0;
        order = 8'h0; ngr = 0;
        for (int c = 0; c < 8; c++) begin
            smp();
            if (ram_en) begin order = {order[6:0], (ram_addr == AW'(8))}; ngr++; end
            nxt();
        end
        idle_inputs();
        chk("rstcnt_order",  32'(order), 32'h01);
        chk("rstcnt_grants", 32'(ngr),   32'd4);

        // Randomized traffic
        reset = 1'b1; smp(); nxt(); reset = 1'b0;
        busy = 0; consec = 0; f_act = 1'b0; m_act = 1'b0; pend = 32'h0; perr = 1'b0;
        f_wait = 0; m_wait = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            dropped = 1'b0;
            if (f_act && busy == 1 && $urandom_range(0, 7) == 0) begin f_act = 1'b0; dropped = 1'b1; end
            if (!f_act && !dropped && $urandom_range(0, 2) != 0) begin
                f_act = 1'b1; f_wait = 0; if_addr = $urandom;
            end
            if_req = f_act;
            dropped = 1'b0;
            if (m_act && busy == 2 && $urandom_range(0, 7) == 0) begin m_act = 1'b0; dropped = 1'b1; end
            if (!m_act && !dropped && $urandom_range(0, 2) != 0) begin
                m_act = 1'b1; m_wait = 0;
                k = int'($urandom_range(0, 9));
                idx = int'($urandom_range(0, NMEM - 1));
                mem_memwrite = 1'($urandom_range(0, 1));
                mem_memread  = !mem_memwrite;
                mem_wdata    = $urandom;
                mem_addr     = 32'(idx * 4);
                if (k == 0) mem_addr = 32'(idx * 4) + $urandom_range(1, 3);
                if (k == 1) mem_addr = 32'((NMEM + int'($urandom_range(0, 1000))) * 4);
                if (k == 2) begin mem_memread = 1'b1; mem_memwrite = 1'b1; end
            end
            if (!m_act) begin mem_memread = 1'b0; mem_memwrite = 1'b0; end
            smp();

            e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_ifr = 0; e_mr = 0; e_me = 0; e_ii = 0; e_md = 0;
            mreq = mem_memread || mem_memwrite;
            if (busy == 0) begin
                if (if_req || mreq) begin
                    take_f = if_req && (!mreq || consec == STARVE_MAX);
                    if (take_f) begin
                        e_en = 1; e_addr = (if_addr >> 2) % NMEM;
                        pend = shadow[e_addr]; consec = 0; busy = 1;
                    end else begin
                        busy = 2;
                        consec = if_req ? ((consec < STARVE_MAX) ? consec + 1 : consec) : 0;
                        perr = (mem_addr % 4 != 0) || ((mem_addr >> 2) >= NMEM) || (mem_memread && mem_memwrite);
                        pend = 32'h0;
                        if (!perr) begin
                            e_en = 1; e_we = mem_memwrite; e_addr = mem_addr >> 2;
                            if (mem_memwrite) begin e_wd = mem_wdata; shadow[e_addr] = mem_wdata; end
                            else pend = shadow[e_addr];
                        end
                    end
                end else begin
                    consec = 0;
                end
            end else begin
                if (busy == 1) begin e_ifr = 1; e_ii = pend; end
                else begin e_mr = 1; e_me = perr; e_md = pend; end
                busy = 0;
            end

            chk("rnd_ram_en",    32'(ram_en),    32'(e_en));
            chk("rnd_ram_we",    32'(ram_we),    32'(e_we));
            chk("rnd_ram_addr",  32'(ram_addr),  e_addr);
            if (e_we || !e_en) chk("rnd_ram_wdata", ram_wdata, e_wd);
            chk("rnd_if_ready",  32'(if_ready),  32'(e_ifr));
            chk("rnd_if_instr",  if_instr,       e_ii);
            chk("rnd_mem_ready", 32'(mem_ready), 32'(e_mr));
            chk("rnd_mem_err",   32'(mem_err),   32'(e_me));
            chk("rnd_memdata",   mem_memdata,    e_md);

            if (f_act) begin
                if (if_ready) begin chk("rnd_fetch_wait_le8", 32'(f_wait <= 8), 32'd1); f_act = 1'b0; end
                else f_wait++;
            end
            if (m_act) begin
                if (mem_ready) begin chk("rnd_data_wait_le3", 32'(m_wait <= 3), 32'd1); m_act = 1'b0; end
                else m_wait++;
            end
            nxt();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
